// File: rtl/back_end_pkg.sv
// Shared state encoding and default widths for the back_end output stage.
package back_end_pkg;

  localparam int unsigned DEFAULT_DATA_W = 32;
  localparam int unsigned DEFAULT_ADDR_W = 12;
  localparam int unsigned DEFAULT_SIZE_W = 16;
  localparam int unsigned DEFAULT_DEPTH  = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/be_fifo.sv
// Small synchronous FIFO with registered occupancy count; DEPTH must be a power of two.
module be_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [DATA_W-1:0]            wdata,
  output logic [DATA_W-1:0]            rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q;
  logic [PtrW-1:0]   rd_ptr_q;
  logic [CntW-1:0]   count_q;

  always_ff @(posedge aclk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/back_end.sv
// Output stage: buffers front-end result words and writes them to consecutive memory addresses.
// Optional stall counter output enabled by defining BACK_END_STALL_CNT_EN.
module back_end
  import back_end_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W,
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
  parameter int unsigned SIZE_W = DEFAULT_SIZE_W,
  parameter int unsigned DEPTH  = DEFAULT_DEPTH
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              start,
  input  logic [SIZE_W-1:0] size,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              wr,
  input  logic [DATA_W-1:0] din,
  output logic              full,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_dout,
  input  logic              mem_ready,
  output logic              done,
  output logic              err
`ifdef BACK_END_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);

  state_e            state_q;
  logic [SIZE_W-1:0] size_q;
  logic [SIZE_W-1:0] acc_cnt_q;
  logic [SIZE_W-1:0] wr_cnt_q;
  logic [ADDR_W-1:0] base_q;
  logic              err_q;

  logic              run;
  logic              push;
  logic              pop;
  logic              empty;
  logic              last_commit;
  logic              err_set;
  logic [DATA_W-1:0] head;
  logic [CntW-1:0]   count;

  be_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .aclk   (aclk),
    .areset (areset),
    .push   (push),
    .pop    (pop),
    .wdata  (din),
    .rdata  (head),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

  assign run         = (state_q == StRun);
  assign push        = wr & run & ~full & (acc_cnt_q < size_q);
  assign err_set     = wr & ~push;
  assign mem_ce      = run & ~empty;
  assign mem_we      = mem_ce;
  assign pop         = mem_ce & mem_ready;
  assign mem_dout    = mem_ce ? head : '0;
  assign mem_addr    = base_q + ADDR_W'(wr_cnt_q);
  // Jump to DONE on the final commit so done rises the very next cycle.
  assign last_commit = pop & ((wr_cnt_q + 1'b1) == size_q);
  assign done        = (state_q == StDone);
  assign err         = err_q;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q   <= StIdle;
      size_q    <= '0;
      base_q    <= '0;
      acc_cnt_q <= '0;
      wr_cnt_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            err_q     <= 1'b0;
            acc_cnt_q <= '0;
            wr_cnt_q  <= '0;
            if (size == '0) begin
              state_q <= StDone;
            end else begin
              state_q <= StRun;
              size_q  <= size;
              base_q  <= base_addr;
            end
          end
        end
        StRun: begin
          if (push) acc_cnt_q <= acc_cnt_q + 1'b1;
          if (pop)  wr_cnt_q  <= wr_cnt_q + 1'b1;
          if (last_commit || ((wr_cnt_q == size_q) && (count == '0))) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          if (!start) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
      // A dropped word always flags, even in the cycle that leaves IDLE.
      if (err_set) err_q <= 1'b1;
    end
  end

`ifdef BACK_END_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge aclk) begin
    if (areset) begin
      stall_cnt_q <= '0;
    end else if ((state_q == StIdle) && start && (size != '0)) begin
      stall_cnt_q <= '0;
    end else if (mem_ce && !mem_ready && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_back_end.sv
// Self-checking bench for back_end: table-driven transfers plus hand-written corner sequences.
module tb_back_end;

  localparam int DEPTH = 4;

  logic        aclk;
  logic        areset;
  logic        start;
  logic [15:0] size;
  logic [11:0] base_addr;
  logic        wr;
  logic [31:0] din;
  logic        full;
  logic        mem_ce;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_dout;
  logic        mem_ready;
  logic        done;
  logic        err;
`ifdef BACK_END_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  back_end dut (
    .aclk      (aclk),
    .areset    (areset),
    .start     (start),
    .size      (size),
    .base_addr (base_addr),
    .wr        (wr),
    .din       (din),
    .full      (full),
    .mem_ce    (mem_ce),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_dout  (mem_dout),
    .mem_ready (mem_ready),
    .done      (done),
    .err       (err)
`ifdef BACK_END_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  typedef struct {
    int          size;
    logic [11:0] base;
    int          nwr;
    int          stall;
    bit          gate;
    bit          rnd;
    bit          exp_err;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_commit_cyc = -10;
  int          step_cyc;
  logic        done_s;
  logic [43:0] exp_q[$];
  int          mcnt = 0;
  int          acc_m = 0;
  int          size_m = 0;
  logic [11:0] base_m = '0;
  bit          run_m = 0;
  bit          held = 0;
  logic [43:0] h_word;

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  always @(posedge aclk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [43:0] act, input logic [43:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory-side monitor: pops the scoreboard on every accepted write, checks hold during stalls.
  always @(negedge aclk) begin
    if (mem_ce === 1'b1) begin
      if (held) chk("hold_stable", {mem_addr, mem_dout}, h_word);
      if (mem_ready === 1'b1) begin
        held = 0;
        last_commit_cyc = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got %h expected none", {mem_addr, mem_dout});
        end else begin
          chk("write", {mem_addr, mem_dout}, exp_q.pop_front());
        end
      end else begin
        held = 1;
        h_word = {mem_addr, mem_dout};
      end
    end else begin
      held = 0;
    end
  end

  // One clock cycle from the front-end's view, with a FIFO occupancy model.
  task automatic step(input logic w, input logic [31:0] d, input logic rdy);
    bit push_m;
    bit pop_m;
    wr = w;
    din = d;
    mem_ready = rdy;
    push_m = run_m && w && (mcnt < DEPTH) && (acc_m < size_m);
    pop_m  = run_m && (mcnt > 0) && rdy;
    if (push_m) begin
      exp_q.push_back({base_m + acc_m[11:0], d});
      acc_m++;
    end
    @(negedge aclk);
    chk("full", full, (mcnt == DEPTH));
    chk("mem_ce", mem_ce, (run_m && mcnt > 0));
    chk("mem_we", mem_we, (run_m && mcnt > 0));
    done_s = done;
    step_cyc = cyc;
    mcnt = mcnt + int'(push_m) - int'(pop_m);
    @(posedge aclk);
    #1;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_full", full, 0);
    chk("rst_mem_ce", mem_ce, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_dout", mem_dout, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
  endtask

  task automatic run_xfer(input vec_t v);
    int  sent;
    int  i;
    bit  seen;
    logic w;
    logic rdy;
    start = 1'b1;
    size = v.size[15:0];
    base_addr = v.base;
    step(1'b0, '0, 1'b1);
    start = 1'b0;
    run_m = 1;
    size_m = v.size;
    base_m = v.base;
    acc_m = 0;
    mcnt = 0;
    sent = 0;
    i = 0;
    while (sent < v.nwr && i < 200) begin
      rdy = (i >= v.stall) ? (v.rnd ? 1'($urandom_range(0, 1)) : 1'b1) : 1'b0;
      w = (!v.gate || mcnt < DEPTH);
      if (w) sent++;
      step(w, $urandom, rdy);
      i++;
    end
    if (sent < v.nwr) chk("strobe_timeout", sent, v.nwr);
    seen = 0;
    for (int k = 0; k < 60 && !seen; k++) begin
      step(1'b0, '0, 1'b1);
      if (done_s === 1'b1) seen = 1;
    end
    if (!seen) begin
      chk("done_timeout", 0, 1);
    end else begin
      chk("done_latency", step_cyc, last_commit_cyc + 1);
      chk("err", err, v.exp_err);
      chk("queue_empty", exp_q.size(), 0);
    end
    run_m = 0;
    step(1'b0, '0, 1'b1);
    chk("back_idle_done", done_s, 0);
    chk("err_sticky", err, v.exp_err);
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{5, 12'h100, 5, 0, 1, 0, 0};
    vecs[1] = '{8, 12'h200, 8, 10, 1, 0, 0};
    vecs[2] = '{2, 12'h300, 3, 0, 1, 0, 1};
    vecs[3] = '{4, 12'hFFE, 4, 0, 1, 0, 0};
    vecs[4] = '{8, 12'h050, 10, 5, 0, 0, 1};
    vecs[5] = '{7, 12'h010, 7, 0, 1, 1, 0};

    areset = 1'b1;
    start = 1'b0;
    size = '0;
    base_addr = '0;
    wr = 1'b0;
    din = '0;
    mem_ready = 1'b1;
    @(posedge aclk);
    #1;
    @(negedge aclk);
    chk_reset_outputs();
    @(posedge aclk);
    #1;
    areset = 1'b0;

    foreach (vecs[n]) run_xfer(vecs[n]);

    // Zero-length transfer: straight to DONE, held while start stays high.
    start = 1'b1;
    size = '0;
    base_addr = 12'h123;
    step(1'b0, '0, 1'b1);
    chk("sz0_idle", done_s, 0);
    step(1'b0, '0, 1'b1);
    chk("sz0_done", done_s, 1);
    step(1'b0, '0, 1'b1);
    chk("sz0_hold", done_s, 1);
    chk("sz0_err", err, 0);
    start = 1'b0;
    step(1'b0, '0, 1'b1);
    chk("sz0_last_done", done_s, 1);
    step(1'b0, '0, 1'b1);
    chk("sz0_back_idle", done_s, 0);

    // Reset in the middle of a transfer with three words buffered.
    start = 1'b1;
    size = 16'd6;
    base_addr = 12'h040;
    step(1'b0, '0, 1'b1);
    start = 1'b0;
    run_m = 1;
    size_m = 6;
    base_m = 12'h040;
    acc_m = 0;
    mcnt = 0;
    repeat (3) step(1'b1, $urandom, 1'b0);
    areset = 1'b1;
    step(1'b0, '0, 1'b0);
    areset = 1'b0;
    exp_q.delete();
    run_m = 0;
    mcnt = 0;
    mem_ready = 1'b1;
    @(negedge aclk);
    chk_reset_outputs();
    @(posedge aclk);
    #1;
    run_xfer('{2, 12'h7F0, 2, 0, 1, 0, 0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/back_end.md
Name: back_end

Overview:
- Output stage directly downstream of the memory-mapped coprocessor front-end controller.
- Accepts result words strobed by the front-end's `wr`, buffers them in a small FIFO, and writes them to the output memory at consecutive addresses.
- Drives `full` back to the front-end as backpressure.
- Counts committed words against the configured transfer size and raises `done` when the last word is in memory.

Parameters:
DATA_W, 32, width of result words and memory write data
ADDR_W, 12, output memory address width
SIZE_W, 16, width of transfer size (words)
DEPTH, 4, FIFO depth in words; power of two, >=2

Ports:
aclk  in  1  clock; all logic on rising edge
areset  in  1  synchronous active-high reset
start  in  1  level; begins a transfer when sampled in IDLE
size  in  SIZE_W  words to commit; sampled with start
base_addr  in  ADDR_W  first output address; sampled with start
wr  in  1  front-end write strobe; din valid this cycle
din  in  DATA_W  result word
full  out  1  FIFO cannot accept a word this cycle
mem_ce  out  1  memory access request
mem_we  out  1  memory write enable (equals mem_ce)
mem_addr  out  ADDR_W  write address
mem_dout  out  DATA_W  write data
mem_ready  in  1  memory accepts the access this cycle
done  out  1  all size words committed
err  out  1  sticky: overflow or excess write

Behaviour:
- Clocking and reset: one clock, `aclk`. Reset `areset` is synchronous and active-high.
- On reset: state=IDLE; FIFO empty; counters=0; full=0, mem_ce=0, mem_we=0, mem_addr=0, mem_dout=0, done=0, err=0.
- Reset asserted mid-transfer:
  - Discards the FIFO contents and the transfer.
  - Asserts no memory access in the following cycle.
- FSM: IDLE, RUN, DONE.
  - IDLE:
    - start=1 and size==0 -> DONE.
    - start=1 and size!=0 -> RUN; latch size and base_addr; clear acc_cnt and wr_cnt.
  - RUN: -> DONE when wr_cnt==size_q and FIFO empty.
  - DONE: done=1. -> IDLE when start=0; otherwise stay.
- FIFO:
  - Registered, DEPTH entries, occupancy count 0..DEPTH.
  - full = (count==DEPTH), combinational from registered count only, so the front-end may gate `wr` on it in the same cycle.
  - Push when wr=1, state=RUN, full=0 and acc_cnt<size_q. acc_cnt increments on each push.
  - Simultaneous push and pop: count unchanged.
- Drain:
  - mem_ce=mem_we=1 whenever state=RUN and the FIFO is non-empty.
  - mem_dout = FIFO head.
  - mem_addr = base_q + wr_cnt, truncated modulo 2^ADDR_W (wraps silently).
  - A word commits (pop, wr_cnt++) in a cycle with mem_ce & mem_ready.
  - mem_ce holds the same addr/data until mem_ready=1.
- Latency: a word pushed in cycle n is on the memory bus no earlier than n+1. Throughput is 1 word/cycle with mem_ready=1.
- Error conditions (word dropped, err set sticky; err clears only on reset or on leaving IDLE via start):
  - wr=1 while full=1.
  - wr=1 when acc_cnt==size_q.
  - wr=1 in IDLE or DONE.
- done rises the cycle after the final commit (or the cycle after start when size==0).
- Counters are SIZE_W wide; size up to 2^SIZE_W-1 is supported.

Optional Feature:
- Macro: BACK_END_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt [31:0], counting RUN cycles where mem_ce=1 and mem_ready=0.
  - stall_cnt clears on the IDLE->RUN transition and on reset; saturates at 2^32-1.
- Undefined: port and counter are absent. All other behaviour is identical.

Decomposition:
- Package back_end_pkg holds:
  - the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - default widths DATA_W, ADDR_W, SIZE_W, DEPTH.
- One sub-module, be_fifo: synchronous FIFO with push/pop/count/full/empty and data head, parameterised by DATA_W and DEPTH.
- FSM, counters and address generation live in back_end.

Test Plan:
1. size=5, base=0x100, wr every cycle, mem_ready=1 -> writes 0x100..0x104 with din in order; full never 1; done 1 cycle after 5th commit; err=0.
2. size=8, DEPTH=4, mem_ready=0 for 10 cycles -> full=1 after 4 pushes; mem_addr/data held stable; after release all 8 commit in order; err=0.
3. start with size=0 -> DONE next cycle, done=1, no mem_ce; start low -> IDLE.
4. size=2, three wr strobes -> two commits; third word dropped; err=1; done asserted normally.
5. base=0xFFE (ADDR_W=12), size=4 -> addresses 0xFFE, 0xFFF, 0x000, 0x001.
6. areset pulse after 3 of 6 words pushed -> next cycle all outputs at reset values; FIFO empty; a new start with size=2 completes cleanly.
